// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction ROM and
// presents one instruction per cycle to decode, with stall-hold, redirect and halt.
module ifetch_unit #(
  parameter int              PC_W      = 12,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_WORD  = 16'h0000,
  parameter logic [15:0]     HALT_WORD = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic            o_rom_rd,
  output logic [PC_W-1:0] o_rom_addr,
  input  logic [15:0]     i_rom_data,
  output logic [15:0]     o_instr,
  output logic [PC_W-1:0] o_instr_pc,
  output logic [PC_W-1:0] o_pc_plus1,
  output logic            o_instr_valid
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_instr_pc;
  logic            r_instr_valid;
  logic [15:0]     r_hold_q;

  logic [15:0]     w_instr;
  logic [PC_W-1:0] w_fetch_addr;
  logic            w_active;
  logic            w_halt_seen;
  logic            w_issue;
  logic            w_capture;
  logic            w_retire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_issue) begin
      w_state_next = S_RUN;
    end else begin
      case (r_state)
        S_BOOT: w_state_next = S_RUN;
        S_RUN: begin
          if (w_capture) begin
            w_state_next = S_HOLD;
          end else if (w_retire) begin
            w_state_next = S_HALT;
          end
        end
        S_HOLD: begin
          if (w_retire) begin
            w_state_next = S_HALT;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    w_instr = NOP_WORD;
    if (r_instr_valid) begin
      case (r_state)
        S_RUN:   w_instr = i_rom_data;
        S_HOLD:  w_instr = r_hold_q;
        default: w_instr = NOP_WORD;
      endcase
    end
    w_active     = (r_state == S_RUN) || (r_state == S_HOLD);
    w_halt_seen  = r_instr_valid && (w_instr == HALT_WORD);
    // A halt word that is still held by a stall only retires once decode accepts it.
    w_issue      = !rst && (i_redirect || (w_active && !i_stall && !w_halt_seen));
    w_capture    = (r_state == S_RUN) && i_stall && !i_redirect;
    w_retire     = w_active && !i_stall && !i_redirect && w_halt_seen;
    w_fetch_addr = i_redirect ? i_redirect_pc : r_pc;
  end

  assign o_rom_rd      = w_issue;
  assign o_rom_addr    = w_fetch_addr;
  assign o_instr       = w_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_pc_plus1    = r_instr_pc + PC_W'(1);
  assign o_instr_valid = r_instr_valid;

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_hold_q      <= NOP_WORD;
    end else begin
      if (w_issue) begin
        r_pc          <= w_fetch_addr + PC_W'(1);
        r_instr_pc    <= w_fetch_addr;
        r_instr_valid <= 1'b1;
      end else if (w_retire) begin
        r_instr_valid <= 1'b0;
      end
      // ROM data is only valid for one cycle, so a stalled instruction is parked here.
      if (w_capture) begin
        r_hold_q <= i_rom_data;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized stall,
// redirect and reset traffic compared against a cycle-level behavioural model.
module tb_ifetch_unit;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic        stall, redirect;
  logic [11:0] redirect_pc;
  logic        rom_rd, rom_rd_w;
  logic [11:0] rom_addr, rom_addr_w;
  logic [15:0] rom_data, rom_data_w;
  logic [15:0] instr, instr_w;
  logic [11:0] instr_pc, instr_pc_w, pc_plus1, pc_plus1_w;
  logic        instr_valid, instr_valid_w;

  logic [15:0] mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // Behavioural model of what decode should see
  logic        m_boot, m_halted, m_valid;
  logic [15:0] m_instr;
  logic [11:0] m_cur, m_next;

  always #5 clk = ~clk;

  ifetch_unit #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_rom_rd(rom_rd), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_instr(instr), .o_instr_pc(instr_pc),
    .o_pc_plus1(pc_plus1), .o_instr_valid(instr_valid)
  );

  ifetch_unit #(.PC_W(12), .RESET_PC(12'hFFE)) dut_wrap (
    .clk(clk), .rst(rst_w), .i_stall(1'b0), .i_redirect(1'b0),
    .i_redirect_pc(12'h000), .o_rom_rd(rom_rd_w), .o_rom_addr(rom_addr_w),
    .i_rom_data(rom_data_w), .o_instr(instr_w), .o_instr_pc(instr_pc_w),
    .o_pc_plus1(pc_plus1_w), .o_instr_valid(instr_valid_w)
  );

  // Synchronous ROMs; junk when not read so stale data cannot pass as valid
  always @(posedge clk) begin
    rom_data   <= rom_rd   ? mem[rom_addr]   : 16'($urandom);
    rom_data_w <= rom_rd_w ? mem[rom_addr_w] : 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_valid  = 1'b0;
    m_instr  = NOP;
    m_cur    = 12'h000;
    m_next   = 12'h000;
  endtask

  task automatic cyc(input logic rs, input logic s, input logic r, input logic [11:0] rp);
    logic        erd;
    logic [11:0] eaddr;
    logic [15:0] ei;
    logic [11:0] ep1;
    @(negedge clk);
    rst = rs; stall = s; redirect = r; redirect_pc = rp;
    #1;
    n_cyc++;
    if (rs) model_reset();
    erd   = !rs && (r || (!m_boot && !m_halted && !s && !(m_valid && m_instr == HALT)));
    eaddr = r ? rp : m_next;
    ei    = m_valid ? m_instr : NOP;
    ep1   = m_cur + 12'd1;
    check("instr_valid", instr_valid, m_valid);
    check("instr", instr, ei);
    check("instr_pc", instr_pc, m_cur);
    check("pc_plus1", pc_plus1, ep1);
    check("rom_rd", rom_rd, erd);
    if (erd || rs) check("rom_addr", rom_addr, eaddr);
    $display("cyc %0d rst=%b stall=%b redir=%b/%h | rd=%b addr=%h valid=%b pc=%h instr=%h",
             n_cyc, rs, s, r, rp, rom_rd, rom_addr, instr_valid, instr_pc, instr);
    if (!rs) begin
      if (erd) begin
        m_instr  = mem[eaddr];
        m_cur    = eaddr;
        m_next   = eaddr + 12'd1;
        m_valid  = 1'b1;
        m_boot   = 1'b0;
        m_halted = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!s && m_valid && m_instr == HALT) begin
        m_valid  = 1'b0;
        m_halted = 1'b1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
    mem[7] = HALT;
    rst = 1'b1; rst_w = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 12'h000;
    model_reset();

    // Wrap-around instance: RESET_PC = 0xFFE
    repeat (2) @(negedge clk);
    rst_w = 1'b0;
    #1 check("wrap_boot_valid", instr_valid_w, 1'b0);
    @(negedge clk); #1;
    check("wrap_rd", rom_rd_w, 1'b1);
    check("wrap_addr", rom_addr_w, 12'hFFE);
    @(negedge clk); #1;
    check("wrap_pc0", instr_pc_w, 12'hFFE);
    check("wrap_instr0", instr_w, 16'h1FFE);
    @(negedge clk); #1;
    check("wrap_pc1", instr_pc_w, 12'hFFF);
    check("wrap_plus1", pc_plus1_w, 12'h000);
    @(negedge clk); #1;
    check("wrap_pc2", instr_pc_w, 12'h000);
    check("wrap_instr2", instr_w, 16'h1000);

    // Reset release and boot
    cyc(1, 0, 0, 0);
    check("reset_instr", instr, NOP);
    cyc(0, 0, 0, 0);
    check("boot_rd", rom_rd, 1'b0);
    cyc(0, 0, 0, 0);
    check("first_issue_rd", rom_rd, 1'b1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    check("pc4", instr_pc, 12'd4);

    // Stall three cycles on instr_pc 5
    repeat (3) cyc(0, 1, 0, 0);
    check("stall_rd", rom_rd, 1'b0);
    cyc(0, 0, 0, 0);
    check("hold_pc", instr_pc, 12'd5);
    check("hold_instr", instr, 16'h1005);
    cyc(0, 0, 0, 0);
    check("after_hold_pc", instr_pc, 12'd6);

    // Halt at 7
    cyc(0, 0, 0, 0);
    check("halt_shown", instr, HALT);
    repeat (4) cyc(0, 0, 0, 0);
    check("halted_valid", instr_valid, 1'b0);

    // Redirects, with and without concurrent stall
    cyc(0, 0, 1, 12'h010);
    cyc(0, 0, 1, 12'h040);
    check("redir_pc10", instr_pc, 12'h010);
    cyc(0, 0, 0, 0);
    check("redir_pc40", instr_pc, 12'h040);
    check("redir_instr40", instr, 16'h1040);
    cyc(0, 0, 1, 12'h010);
    check("redir_pc41", instr_pc, 12'h041);
    cyc(0, 1, 1, 12'h040);
    cyc(0, 0, 0, 0);
    check("stall_redir_pc40", instr_pc, 12'h040);
    cyc(0, 0, 1, 12'h000);
    cyc(0, 0, 0, 0);
    check("resume_pc0", instr_pc, 12'h000);
    repeat (10) cyc(0, 0, 0, 0);

    // Reset while holding instr_pc 9
    cyc(0, 0, 1, 12'h008);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("hold9_pc", instr_pc, 12'd9);
    cyc(1, 1, 0, 0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_pc", instr_pc, 12'h000);
    repeat (3) cyc(0, 0, 0, 0);
    check("refetch_instr", instr, 16'h1000);

    // Randomized traffic with sprinkled halt words
    for (int i = 0; i < 4096; i++) if (i % 17 == 16) mem[i] = HALT;
    for (int n = 0; n < 1500; n++) begin
      logic rs, s, r;
      rs = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      r  = !rs && ($urandom_range(0, 11) == 0);
      cyc(rs, s, r, 12'($urandom_range(0, 4095)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
